// File: rtl/time_keeper_pkg.sv
// Shared constants and helpers for the 12-hour running clock core.
package time_keeper_pkg;

    localparam logic [3:0] MODE_TIME_SET = 4'b0000;
    localparam logic [6:0] SEC_MAX       = 7'd59;
    localparam logic [6:0] MIN_MAX       = 7'd59;
    localparam logic [6:0] HOUR_MAX      = 7'd11;

    // Out-of-range set values collapse to 0 (hour 12 is stored as 0).
    function automatic logic [6:0] clamp_zero(input logic [6:0] v, input logic [6:0] max);
        return (v > max) ? 7'd0 : v;
    endfunction

endpackage

// File: rtl/time_keeper_tick_gen.sv
// Divide-by-(TICK_MAX+1) second divider; TICK flags the terminal count combinationally.
module tick_gen #(
    parameter int TICK_MAX = 999
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLEAR,
    output logic TICK
);

    localparam int CW = (TICK_MAX < 1) ? 1 : $clog2(TICK_MAX + 1);
    localparam logic [CW-1:0] TERM = CW'(TICK_MAX);

    logic [CW-1:0] count;

    assign TICK = !CLEAR && (count == TERM);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET)
            count <= '0;
        else if (CLEAR || TICK)
            count <= '0;
        else
            count <= count + 1'b1;
    end

endmodule

// File: rtl/time_keeper.sv
// Running 12-hour clock: paused in set mode, loads the set values on exit, then counts seconds.
module time_keeper
    import time_keeper_pkg::*;
#(
    parameter int         TICK_MAX = 999,
    parameter logic [3:0] SET_MODE = MODE_TIME_SET
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] MODE,
    input  logic       SET_MERIDIEM,
    input  logic [6:0] SET_HOUR,
    input  logic [6:0] SET_MIN,
    input  logic [6:0] SET_SEC,
    output logic       MERIDIEM,
    output logic [6:0] HOUR,
    output logic [6:0] MIN,
    output logic [6:0] SEC,
    output logic       TICK_1S,
    output logic       DAY_PULSE
);

    logic [3:0] mode_q;
    logic       in_set;
    logic       load;
    logic       tick;
    logic       day_end;

    assign in_set = (MODE == SET_MODE);
    assign load   = !in_set && (mode_q == SET_MODE);

    // Clearing on the load cycle makes the first tick land TICK_MAX+1 cycles later.
    tick_gen #(.TICK_MAX(TICK_MAX)) u_tick (
        .CLK   (CLK),
        .RESET (RESET),
        .CLEAR (in_set || load),
        .TICK  (tick)
    );

    assign day_end = MERIDIEM && (HOUR == HOUR_MAX) && (MIN == MIN_MAX) && (SEC == SEC_MAX);

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            mode_q    <= SET_MODE;
            MERIDIEM  <= 1'b0;
            HOUR      <= 7'd0;
            MIN       <= 7'd0;
            SEC       <= 7'd0;
            TICK_1S   <= 1'b0;
            DAY_PULSE <= 1'b0;
        end else begin
            mode_q    <= MODE;
            TICK_1S   <= tick;
            DAY_PULSE <= tick && day_end;
            if (load) begin
                MERIDIEM <= SET_MERIDIEM;
                HOUR     <= clamp_zero(SET_HOUR, HOUR_MAX);
                MIN      <= clamp_zero(SET_MIN, MIN_MAX);
                SEC      <= clamp_zero(SET_SEC, SEC_MAX);
            end else if (tick) begin
                if (SEC == SEC_MAX) begin
                    SEC <= 7'd0;
                    if (MIN == MIN_MAX) begin
                        MIN <= 7'd0;
                        if (HOUR == HOUR_MAX) begin
                            HOUR     <= 7'd0;
                            MERIDIEM <= ~MERIDIEM;
                        end else begin
                            HOUR <= HOUR + 7'd1;
                        end
                    end else begin
                        MIN <= MIN + 7'd1;
                    end
                end else begin
                    SEC <= SEC + 7'd1;
                end
            end
        end
    end

endmodule
